reg_file_scoreboard: RTL

- Read side of the write-back path: 32-entry general register file, which is the consumer of the destination selected by the write-register mux (rs, rt or link register 31).
- Provides two registered read ports (A = rs, B = rt) with write-through bypass.
- Tracks in-flight destinations in a pending-write scoreboard and stalls reads of registers whose producer has not yet retired.
- Sits between decode (reads, issue) and write-back (retire).

---
 rtl/reg_file_scoreboard_pkg.sv | 27 ++
 rtl/reg_file_scoreboard_if.sv | 31 +++
 rtl/reg_file_scoreboard_sb.sv | 49 ++++
 rtl/reg_file_scoreboard.sv | 78 +++++++
 4 files changed

// File: rtl/reg_file_scoreboard_pkg.sv
// Shared definitions for the register file read side and the write-register mux.
// RegDst encodings select which instruction field names the destination register.
package reg_file_scoreboard_pkg;

    localparam int DATA_W     = 32;
    localparam int NREG       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int LINK_REG   = 31;

    localparam logic [1:0] RS   = 2'b00;
    localparam logic [1:0] RT   = 2'b01;
    localparam logic [1:0] LINK = 2'b10;

    // Write-register mux: the destination address a given RegDst selects.
    function automatic logic [REG_ADDR_W-1:0] regdst_sel(
        input logic [1:0]            sel,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rt
    );
        case (sel)
            RS:      return rs;
            RT:      return rt;
            default: return REG_ADDR_W'(LINK_REG);
        endcase
    endfunction

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Decode/write-back bundle for the register file: read request, issue and retire.
// The master modport is the pipeline side; the slave modport is the register file.
interface reg_file_scoreboard_if
    import reg_file_scoreboard_pkg::*;
#(
    parameter int DATA_W = reg_file_scoreboard_pkg::DATA_W
);
    logic                  rd_req;
    logic [REG_ADDR_W-1:0] rd_addr_a;
    logic [REG_ADDR_W-1:0] rd_addr_b;
    logic                  rd_stall;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data_a;
    logic [DATA_W-1:0]     rd_data_b;
    logic                  iss_valid;
    logic [REG_ADDR_W-1:0] iss_dest;
    logic                  iss_ready;
    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0]     wr_data;

    modport master (
        output rd_req, rd_addr_a, rd_addr_b, iss_valid, iss_dest, wr_en, wr_addr, wr_data,
        input  rd_stall, rd_valid, rd_data_a, rd_data_b, iss_ready
    );

    modport slave (
        input  rd_req, rd_addr_a, rd_addr_b, iss_valid, iss_dest, wr_en, wr_addr, wr_data,
        output rd_stall, rd_valid, rd_data_a, rd_data_b, iss_ready
    );
endinterface

// File: rtl/reg_file_scoreboard_sb.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on retire.
// A bit being cleared this cycle already counts as free for issue and for reads.
module reg_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int NREG        = reg_file_scoreboard_pkg::NREG,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_dest,
    output logic                  iss_ready,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic                  rd_req,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic                  rd_stall
);
    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_bit
            localparam bit CAN_SET = !(ZERO_REG_EN && gi == 0);
            assign clr_vec[gi]  = wr_en && (wr_addr == REG_ADDR_W'(gi));
            assign set_vec[gi]  = CAN_SET && iss_valid && iss_ready && (iss_dest == REG_ADDR_W'(gi));
            assign busy_vec[gi] = pending_reg[gi] && !clr_vec[gi];
            // A new producer issued on the retire edge keeps the bit set.
            assign pending_next[gi] = set_vec[gi] || (pending_reg[gi] && !clr_vec[gi]);
        end
    endgenerate

    assign iss_ready = iss_valid && !busy_vec[iss_dest];
    assign rd_stall  = rd_req && (busy_vec[rd_addr_a] || busy_vec[rd_addr_b]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end
endmodule

// File: rtl/reg_file_scoreboard.sv
// General register file with two registered read ports, write-through bypass
// and a pending-write scoreboard that stalls reads of not-yet-retired registers.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int DATA_W      = reg_file_scoreboard_pkg::DATA_W,
    parameter int NREG        = reg_file_scoreboard_pkg::NREG,
    parameter bit ZERO_REG_EN = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_file_scoreboard_if.slave  bus
);
    logic [DATA_W-1:0] regs_reg [NREG];
    logic              rd_valid_reg;
    logic [DATA_W-1:0] rd_data_a_reg;
    logic [DATA_W-1:0] rd_data_b_reg;
    logic [DATA_W-1:0] rd_data_a_next;
    logic [DATA_W-1:0] rd_data_b_next;
    logic              rd_accept;
    logic              wr_allowed;

    reg_scoreboard #(
        .NREG        (NREG),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (bus.iss_valid),
        .iss_dest  (bus.iss_dest),
        .iss_ready (bus.iss_ready),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .rd_req    (bus.rd_req),
        .rd_addr_a (bus.rd_addr_a),
        .rd_addr_b (bus.rd_addr_b),
        .rd_stall  (bus.rd_stall)
    );

    assign wr_allowed = bus.wr_en && !(ZERO_REG_EN && bus.wr_addr == '0);
    assign rd_accept  = bus.rd_req && !bus.rd_stall;

    // Retiring data bypasses the array; a hard-wired zero register overrides even that.
    always_comb begin
        rd_data_a_next = regs_reg[bus.rd_addr_a];
        rd_data_b_next = regs_reg[bus.rd_addr_b];
        if (bus.wr_en && bus.wr_addr == bus.rd_addr_a) rd_data_a_next = bus.wr_data;
        if (bus.wr_en && bus.wr_addr == bus.rd_addr_b) rd_data_b_next = bus.wr_data;
        if (ZERO_REG_EN && bus.rd_addr_a == '0) rd_data_a_next = '0;
        if (ZERO_REG_EN && bus.rd_addr_b == '0) rd_data_b_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
        end else if (wr_allowed) begin
            regs_reg[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg  <= 1'b0;
            rd_data_a_reg <= '0;
            rd_data_b_reg <= '0;
        end else begin
            rd_valid_reg <= rd_accept;
            if (rd_accept) begin
                rd_data_a_reg <= rd_data_a_next;
                rd_data_b_reg <= rd_data_b_next;
            end
        end
    end

    assign bus.rd_valid  = rd_valid_reg;
    assign bus.rd_data_a = rd_data_a_reg;
    assign bus.rd_data_b = rd_data_b_reg;
endmodule
